mult_seq: RTL and testbench

//  Sequential shift-add multiplier. Produces a 2*WIDTH-bit product and a
//  one-cycle write strobe that drive the d/en inputs of the 32-bit result

---
 rtl/mult_seq.sv | 113 +++++++++++
 tb/tb_mult_seq.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/mult_seq.sv
// Radix-2 shift-add multiplier: one multiplier bit per clock, 2*WIDTH-bit product
// with a single-cycle write strobe for the downstream result register.
module mult_seq #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               signed_op,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               ready,
  output logic               busy,
  output logic [2*WIDTH-1:0] prod,
  output logic               prod_valid
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state, state_nxt;
  logic [CW-1:0]     cnt;
  logic [2*WIDTH:0]  acc;
  logic [WIDTH-1:0]  mcand;
  logic              neg;
  logic              accept;
  logic              last_iter;

  // Most negative input maps to itself, read back as an unsigned magnitude.
  function automatic logic [WIDTH-1:0] magnitude(input logic signed [WIDTH-1:0] x,
                                                 input logic is_signed);
    logic signed [WIDTH-1:0] nx;
    nx = -x;
    if (is_signed && x[WIDTH-1])
      return $unsigned(nx);
    return $unsigned(x);
  endfunction

  function automatic logic [2*WIDTH-1:0] apply_sign(input logic [2*WIDTH-1:0] mag,
                                                    input logic n);
    return n ? (~mag + 1'b1) : mag;
  endfunction

  // Upper half carries the partial sum, lower half still holds unconsumed multiplier bits.
  function automatic logic [2*WIDTH:0] shift_add(input logic [2*WIDTH:0] cur,
                                                 input logic [WIDTH-1:0] m);
    logic [WIDTH:0] upper;
    upper = cur[2*WIDTH:WIDTH];
    if (cur[0])
      upper = upper + {1'b0, m};
    return {upper, cur[WIDTH-1:0]} >> 1;
  endfunction

  assign accept    = ready & start;
  assign last_iter = (cnt == CW'(WIDTH));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    ready      = 1'b0;
    busy       = 1'b0;
    prod_valid = 1'b0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (start)
          state_nxt = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (last_iter)
          state_nxt = DONE;
      end
      DONE: begin
        ready      = 1'b1;
        prod_valid = 1'b1;
        state_nxt  = start ? RUN : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // One extra RUN cycle after the last iteration applies the sign and loads prod.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      acc   <= '0;
      mcand <= '0;
      neg   <= 1'b0;
      prod  <= '0;
    end else if (accept) begin
      neg   <= signed_op & (a[WIDTH-1] ^ b[WIDTH-1]);
      mcand <= magnitude(a, signed_op);
      acc   <= {{(WIDTH+1){1'b0}}, magnitude(b, signed_op)};
      cnt   <= '0;
    end else if (state == RUN) begin
      if (!last_iter) begin
        acc <= shift_add(acc, mcand);
        cnt <= cnt + CW'(1);
      end else begin
        prod <= apply_sign(acc[2*WIDTH-1:0], neg);
      end
    end
  end

endmodule

// File: tb/tb_mult_seq.sv
// Scoreboard bench for mult_seq: driver queues expected products with their
// accept cycle, a negedge monitor checks every strobe, its latency and prod hold.
module tb_mult_seq;
  localparam int W = 16;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           start = 1'b0;
  logic           signed_op = 1'b0;
  logic [W-1:0]   a = '0;
  logic [W-1:0]   b = '0;
  logic           ready, busy, prod_valid;
  logic [2*W-1:0] prod;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  typedef struct {
    logic [31:0] want;
    int          k;
  } exp_t;
  exp_t sb[$];

  mult_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .signed_op(signed_op),
    .a(a), .b(b), .ready(ready), .busy(busy), .prod(prod), .prod_valid(prod_valid)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic logic [31:0] ref_mul(input logic s, input logic [W-1:0] x,
                                          input logic [W-1:0] y);
    longint px, py, r;
    px = s ? longint'($signed(x)) : longint'({16'b0, x});
    py = s ? longint'($signed(y)) : longint'({16'b0, y});
    r  = px * py;
    return r[31:0];
  endfunction

  // Must be called at a negedge; returns at the negedge after the accept edge.
  task automatic issue(input logic s, input logic [W-1:0] x, input logic [W-1:0] y,
                       input logic [31:0] e, input bit push);
    int n = 0;
    while (!ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!ready) begin
      checks++;
      errors++;
      $display("FAIL issue_timeout: ready stayed 0 for %0d cycles", n);
    end
    start     = 1'b1;
    signed_op = s;
    a         = x;
    b         = y;
    if (push) sb.push_back(exp_t'{e, cyc + 1});
    @(negedge clk);
    start     = 1'b0;
    a         = W'($urandom);
    b         = W'($urandom);
    signed_op = 1'($urandom);
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d results outstanding", sb.size());
      sb.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  // Monitor
  initial begin
    logic [31:0] last_prod = '0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        last_prod = '0;
      end else if (prod_valid) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_strobe: got prod %0h with nothing outstanding", prod);
        end else begin
          e = sb.pop_front();
          chk("prod", 64'(prod), 64'(e.want));
          chk("latency", 64'(cyc), 64'(e.k + 17));
        end
        last_prod = prod;
      end else begin
        chk("prod_hold", 64'(prod), 64'(last_prod));
      end
    end
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k0;
    logic s;
    logic [W-1:0] x, y;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_prod", 64'(prod), 64'h0);
    chk("rst_ready", 64'(ready), 64'h1);
    chk("rst_busy", 64'(busy), 64'h0);
    chk("rst_valid", 64'(prod_valid), 64'h0);
    rst = 1'b0;
    @(negedge clk);

    // T1: timing of a single op
    k0 = cyc + 1;
    issue(1'b0, 16'd3, 16'd5, 32'h0000000F, 1'b1);
    for (int i = 0; i <= 16; i++) begin
      chk("t1_busy", 64'(busy), 64'h1);
      chk("t1_ready", 64'(ready), 64'h0);
      if (i < 16) @(negedge clk);
    end
    @(negedge clk);
    chk("t1_strobe_cycle", 64'(cyc), 64'(k0 + 17));
    chk("t1_valid_hi", 64'(prod_valid), 64'h1);
    chk("t1_busy_done", 64'(busy), 64'h0);
    @(negedge clk);
    chk("t1_valid_lo", 64'(prod_valid), 64'h0);
    chk("t1_prod_hold", 64'(prod), 64'h0000000F);

    // T2/T3 and extra corners, back-to-back through DONE
    issue(1'b0, 16'hFFFF, 16'hFFFF, 32'hFFFE0001, 1'b1);
    issue(1'b1, 16'hFFFF, 16'hFFFF, 32'h00000001, 1'b1);
    issue(1'b1, 16'hFFFE, 16'h0003, 32'hFFFFFFFA, 1'b1);
    issue(1'b1, 16'h8000, 16'h8000, 32'h40000000, 1'b1);
    issue(1'b1, 16'h8000, 16'h0001, 32'hFFFF8000, 1'b1);
    issue(1'b0, 16'h8000, 16'h8000, 32'h40000000, 1'b1);
    issue(1'b1, 16'h7FFF, 16'h8000, 32'hC0008000, 1'b1);
    issue(1'b1, 16'h0000, 16'hFFFB, 32'h00000000, 1'b1);
    issue(1'b1, 16'hFFFF, 16'h0001, 32'hFFFFFFFF, 1'b1);
    drain();

    // T4: start pulses during RUN are ignored; start in DONE is accepted
    issue(1'b0, 16'd1000, 16'd1000, 32'd1000000, 1'b1);
    while (!ready) begin
      start     = 1'b1;
      a         = W'($urandom);
      b         = W'($urandom);
      signed_op = 1'($urandom);
      @(negedge clk);
    end
    issue(1'b1, 16'hFF9C, 16'd25, 32'hFFFFF63C, 1'b1);
    drain();

    // T5: async reset mid-RUN aborts the op
    issue(1'b0, 16'h1234, 16'h5678, 32'h0, 1'b0);
    repeat (7) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("t5_prod", 64'(prod), 64'h0);
    chk("t5_busy", 64'(busy), 64'h0);
    chk("t5_ready", 64'(ready), 64'h1);
    chk("t5_valid", 64'(prod_valid), 64'h0);
    @(negedge clk);
    #2 rst = 1'b0;
    repeat (30) @(negedge clk);
    issue(1'b0, 16'h1234, 16'h5678, 32'h06260060, 1'b1);
    drain();

    // T6: random ops with random gaps against the reference product
    for (int i = 0; i < 300; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      s = 1'($urandom);
      x = W'($urandom);
      y = W'($urandom);
      if (i % 50 == 0) x = 16'h8000;
      issue(s, x, y, ref_mul(s, x, y), 1'b1);
    end
    drain();
    chk("queue_empty", 64'(sb.size()), 64'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
